// File: rtl/fpu_mds_issue.sv
// Issue/retire stage around the FPU multiply/divide/sqrt unit: unpacks and classifies
// one single-precision request, starts the MDS unit, and returns its result to writeback.
module fpu_mds_issue #(
  parameter int unsigned TAG_W     = 5,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [2:0]       req_rm,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mds_start,
  output logic [1:0]       mds_op,
  output logic [2:0]       mds_rm,
  output logic             mds_sign_a,
  output logic             mds_sign_b,
  output logic [7:0]       mds_exp_a,
  output logic [7:0]       mds_exp_b,
  output logic [23:0]      mds_sig_a,
  output logic [23:0]      mds_sig_b,
  output logic             mds_zero_a,
  output logic             mds_zero_b,
  output logic             mds_inf_a,
  output logic             mds_inf_b,
  output logic             mds_nan_a,
  output logic             mds_nan_b,
  output logic             mds_signaling,
  output logic             mds_subnormal_sqrt,
  input  logic [31:0]      mds_out,
  input  logic             mds_done,
  input  logic             mds_of,
  input  logic             mds_uf,
  input  logic             mds_nv,
  input  logic             mds_nx,
  input  logic             mds_dz,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag
);

  // Unpacked operand layout: {sign, exp[7:0], sig[23:0], zero, inf, nan}
  localparam int unsigned FLD_W = 36;
  localparam logic [1:0]  OP_SQRT = 2'b10;
  localparam logic [1:0]  OP_ILL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_kill;
  logic             r_mds_start;
  logic             r_rsp_valid;
  logic [1:0]       r_op;
  logic [2:0]       r_rm;
  logic [TAG_W-1:0] r_tag;
  logic [FLD_W-1:0] r_opa;
  logic [FLD_W-1:0] r_opb;
  logic             r_signaling;
  logic             r_sub_sqrt;
  logic [31:0]      r_result;
  logic [4:0]       r_flags;

  logic             w_accept;
  logic             w_is_sqrt;
  logic [FLD_W-1:0] w_ua;
  logic [FLD_W-1:0] w_ub;
  logic             w_snan_a;
  logic             w_snan_b;
  logic             w_sub_a;
  logic             w_load;
  logic             w_ill;
  logic             w_capture;
  logic             w_kill_d;
  logic             w_start_d;
  logic             w_valid_d;

  function automatic logic [FLD_W-1:0] unpack(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] f;
    logic        zero;
    logic        sub;
    logic [7:0]  ex;
    logic [23:0] sg;
    e    = x[30:23];
    f    = x[22:0];
    zero = (e == 8'h00) && (f == 23'd0);
    sub  = (e == 8'h00) && (f != 23'd0);
    if (zero) begin
      ex = 8'd0;
      sg = 24'd0;
    end else if (sub) begin
      ex = 8'd1;
      sg = {1'b0, f};
    end else begin
      ex = e;
      sg = {1'b1, f};
    end
    return {x[31], ex, sg, zero, (e == 8'hFF) && (f == 23'd0), (e == 8'hFF) && (f != 23'd0)};
  endfunction

  assign w_ua      = unpack(req_a);
  assign w_ub      = unpack(req_b);
  assign w_snan_a  = w_ua[0] && !req_a[22];
  assign w_snan_b  = w_ub[0] && !req_b[22];
  assign w_sub_a   = (req_a[30:23] == 8'h00) && (req_a[22:0] != 23'd0);
  assign w_is_sqrt = (req_op == OP_SQRT);
  assign req_ready = (r_state == S_IDLE) && !flush;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (req_op == OP_ILL) ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mds_done) w_next = (r_kill || flush) ? S_IDLE : S_RESP;
      S_RESP:  if (rsp_ready || flush) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Load/capture strobes and next values of the registered outputs
  always_comb begin
    w_load    = 1'b0;
    w_ill     = 1'b0;
    w_capture = 1'b0;
    w_kill_d  = r_kill;
    case (r_state)
      S_IDLE: begin
        w_load   = w_accept;
        w_ill    = w_accept && (req_op == OP_ILL);
        w_kill_d = 1'b0;
      end
      S_ISSUE: if (flush) w_kill_d = 1'b1;
      S_WAIT: begin
        if (flush) w_kill_d = 1'b1;
        if (mds_done) begin
          w_capture = !(r_kill || flush);
          w_kill_d  = 1'b0;
        end
      end
      default: w_kill_d = 1'b0;
    endcase
    w_start_d = (w_next == S_ISSUE);
    w_valid_d = (w_next == S_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kill      <= 1'b0;
      r_mds_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_op        <= 2'd0;
      r_rm        <= 3'd0;
      r_tag       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_signaling <= 1'b0;
      r_sub_sqrt  <= 1'b0;
      r_result    <= 32'd0;
      r_flags     <= 5'd0;
    end else begin
      r_kill      <= w_kill_d;
      r_mds_start <= w_start_d;
      r_rsp_valid <= w_valid_d;
      if (w_load) begin
        r_op        <= req_op;
        r_rm        <= req_rm;
        r_tag       <= req_tag;
        r_opa       <= w_ua;
        r_opb       <= w_is_sqrt ? '0 : w_ub;
        r_signaling <= w_snan_a || (!w_is_sqrt && w_snan_b);
        r_sub_sqrt  <= w_is_sqrt && w_sub_a;
      end
      if (w_ill) begin
        r_result <= CANON_NAN;
        r_flags  <= 5'b10000;
      end else if (w_capture) begin
        r_result <= mds_out;
        r_flags  <= {mds_nv, mds_dz, mds_of, mds_uf, mds_nx};
      end
    end
  end

  assign mds_start          = r_mds_start;
  assign mds_op             = r_op;
  assign mds_rm             = r_rm;
  assign mds_sign_a         = r_opa[35];
  assign mds_exp_a          = r_opa[34:27];
  assign mds_sig_a          = r_opa[26:3];
  assign mds_zero_a         = r_opa[2];
  assign mds_inf_a          = r_opa[1];
  assign mds_nan_a          = r_opa[0];
  assign mds_sign_b         = r_opb[35];
  assign mds_exp_b          = r_opb[34:27];
  assign mds_sig_b          = r_opb[26:3];
  assign mds_zero_b         = r_opb[2];
  assign mds_inf_b          = r_opb[1];
  assign mds_nan_b          = r_opb[0];
  assign mds_signaling      = r_signaling;
  assign mds_subnormal_sqrt = r_sub_sqrt;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_result         = r_result;
  assign rsp_flags          = r_flags;
  assign rsp_tag            = r_tag;

endmodule

// File: tb/tb_fpu_mds_issue.sv
// Bench for fpu_mds_issue: directed and randomized transactions, with operand
// classification and response timing checked against a transaction-level model.
module tb_fpu_mds_issue;
  localparam int unsigned TW = 5;
  localparam logic [31:0] CANON = 32'h7FC00000;

  logic clk = 1'b0;
  logic reset, flush, req_valid, req_ready;
  logic [1:0] req_op;
  logic [2:0] req_rm;
  logic [31:0] req_a, req_b;
  logic [TW-1:0] req_tag;
  logic mds_start;
  logic [1:0] mds_op;
  logic [2:0] mds_rm;
  logic mds_sign_a, mds_sign_b;
  logic [7:0] mds_exp_a, mds_exp_b;
  logic [23:0] mds_sig_a, mds_sig_b;
  logic mds_zero_a, mds_zero_b, mds_inf_a, mds_inf_b, mds_nan_a, mds_nan_b;
  logic mds_signaling, mds_subnormal_sqrt;
  logic [31:0] mds_out;
  logic mds_done, mds_of, mds_uf, mds_nv, mds_nx, mds_dz;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0] rsp_flags;
  logic [TW-1:0] rsp_tag;

  fpu_mds_issue #(.TAG_W(TW), .CANON_NAN(CANON)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .mds_start(mds_start), .mds_op(mds_op), .mds_rm(mds_rm),
    .mds_sign_a(mds_sign_a), .mds_sign_b(mds_sign_b), .mds_exp_a(mds_exp_a), .mds_exp_b(mds_exp_b),
    .mds_sig_a(mds_sig_a), .mds_sig_b(mds_sig_b), .mds_zero_a(mds_zero_a), .mds_zero_b(mds_zero_b),
    .mds_inf_a(mds_inf_a), .mds_inf_b(mds_inf_b), .mds_nan_a(mds_nan_a), .mds_nan_b(mds_nan_b),
    .mds_signaling(mds_signaling), .mds_subnormal_sqrt(mds_subnormal_sqrt),
    .mds_out(mds_out), .mds_done(mds_done), .mds_of(mds_of), .mds_uf(mds_uf),
    .mds_nv(mds_nv), .mds_nx(mds_nx), .mds_dz(mds_dz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected operand view of the MDS unit for the transaction in flight
  logic ops_check = 1'b0;
  logic [1:0] e_op;
  logic [2:0] e_rm;
  logic e_sa, e_sb, e_za, e_zb, e_ia, e_ib, e_na, e_nb, e_snan, e_subsq;
  logic [7:0] e_ea, e_eb;
  logic [23:0] e_ga, e_gb;

  function automatic void ref_unpack(input logic [31:0] x, output logic s, output logic [7:0] ex,
                                     output logic [23:0] sg, output logic z, output logic inf,
                                     output logic nan, output logic snan, output logic sub);
    int unsigned e, f;
    e    = (x >> 23) & 32'hFF;
    f    = x & 32'h7FFFFF;
    s    = x[31];
    z    = (e == 0) && (f == 0);
    sub  = (e == 0) && (f != 0);
    inf  = (e == 255) && (f == 0);
    nan  = (e == 255) && (f != 0);
    snan = nan && (f < 32'h400000);
    ex   = z ? 8'd0 : (sub ? 8'd1 : 8'(e));
    sg   = z ? 24'd0 : (sub ? 24'(f) : 24'(f + 32'h800000));
  endfunction

  task automatic set_exp(input logic [1:0] op, input logic [2:0] rm, input logic [31:0] a,
                         input logic [31:0] b);
    logic sna, snb, suba, subb;
    e_op = op;
    e_rm = rm;
    ref_unpack(a, e_sa, e_ea, e_ga, e_za, e_ia, e_na, sna, suba);
    ref_unpack(b, e_sb, e_eb, e_gb, e_zb, e_ib, e_nb, snb, subb);
    if (op == 2'b10) begin
      {e_sb, e_eb, e_gb, e_zb, e_ib, e_nb} = '0;
      snb = 1'b0;
    end
    e_snan  = sna | snb;
    e_subsq = (op == 2'b10) && suba;
  endtask

  always @(negedge clk) begin
    if (ops_check) begin
      chk("mds_op", mds_op, e_op);
      chk("mds_rm", mds_rm, e_rm);
      chk("a_fields", {mds_sign_a, mds_exp_a, mds_sig_a, mds_zero_a, mds_inf_a, mds_nan_a},
          {e_sa, e_ea, e_ga, e_za, e_ia, e_na});
      chk("b_fields", {mds_sign_b, mds_exp_b, mds_sig_b, mds_zero_b, mds_inf_b, mds_nan_b},
          {e_sb, e_eb, e_gb, e_zb, e_ib, e_nb});
      chk("signaling", mds_signaling, e_snan);
      chk("subnormal_sqrt", mds_subnormal_sqrt, e_subsq);
    end
  end

  // fl_at: -1 none, 0 flush during the start cycle, k flush on the k-th waiting cycle.
  // resp_end: 0 rsp_ready, 1 flush, 2 both together.
  task automatic do_op(input logic [1:0] op, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] tag, input int dly,
                       input int fl_at, input bit spur, input int bp, input int resp_end);
    logic [31:0] x_res;
    logic [4:0]  x_flg;
    bit killed;
    killed = 0;
    @(posedge clk); #1;
    req_valid = 1; req_op = op; req_rm = rm; req_a = a; req_b = b; req_tag = tag;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 0; req_a = $urandom; req_b = $urandom; req_tag = TW'($urandom);
    req_op = 2'($urandom); req_rm = 3'($urandom);
    set_exp(op, rm, a, b);
    if (op != 2'b11) begin
      ops_check = 1;
      if (spur) begin mds_done = 1; mds_out = $urandom; end
      if (fl_at == 0) begin flush = 1; killed = 1; end
      @(negedge clk);
      chk("start_pulse", mds_start, 1'b1);
      chk("rsp_valid_issue", rsp_valid, 1'b0);
      chk("req_ready_busy", req_ready, 1'b0);
      for (int c = 1; c <= dly; c++) begin
        @(posedge clk); #1;
        mds_done = 0; flush = 0;
        if (c == dly) begin
          mds_done = 1; mds_out = $urandom;
          {mds_nv, mds_dz, mds_of, mds_uf, mds_nx} = 5'($urandom);
        end
        if (fl_at == c) begin flush = 1; killed = 1; end
        @(negedge clk);
        chk("start_low_wait", mds_start, 1'b0);
        chk("rsp_valid_wait", rsp_valid, 1'b0);
        chk("req_ready_wait", req_ready, 1'b0);
      end
      x_res = mds_out;
      x_flg = {mds_nv, mds_dz, mds_of, mds_uf, mds_nx};
      @(posedge clk); #1;
      mds_done = 0; flush = 0; ops_check = 0;
    end else begin
      x_res = CANON;
      x_flg = 5'b10000;
    end
    if (killed) begin
      @(negedge clk);
      chk("killed_no_valid", rsp_valid, 1'b0);
      chk("killed_req_ready", req_ready, 1'b1);
      chk("killed_no_start", mds_start, 1'b0);
    end else begin
      for (int c = 0; c <= bp; c++) begin
        if (c == bp) begin
          if (resp_end != 1) rsp_ready = 1;
          if (resp_end != 0) flush = 1;
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_result", rsp_result, x_res);
        chk("rsp_flags", rsp_flags, x_flg);
        chk("rsp_tag", rsp_tag, tag);
        chk("req_ready_resp", req_ready, 1'b0);
        chk("start_low_resp", mds_start, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 0; flush = 0;
      end
      @(negedge clk);
      chk("rsp_valid_drop", rsp_valid, 1'b0);
      chk("req_ready_back", req_ready, 1'b1);
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 11))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h7F800000;
      3: return 32'hFF800000;
      4: return 32'h7FC00000;
      5: return 32'h7F800001;
      6: return 32'h00000001;
      7: return 32'h807FFFFF;
      8: return 32'hFFA00000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 0; flush = 0; req_valid = 0; req_op = 0; req_rm = 0; req_a = 0; req_b = 0;
    req_tag = 0; mds_out = 0; mds_done = 0; rsp_ready = 0;
    {mds_of, mds_uf, mds_nv, mds_nx, mds_dz} = '0;
    #12;
    chk("rst_start", mds_start, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_flags_tag", {rsp_flags, rsp_tag}, '0);
    chk("rst_ops", {mds_exp_a, mds_sig_a, mds_sig_b, mds_signaling}, '0);
    @(negedge clk); reset = 1;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1'b1);

    // FMUL 2.0 * 3.0 = 6.0
    do_op(2'b00, 3'b000, 32'h40000000, 32'h40400000, 5'd3, 3, -1, 0, 0, 0);
    chk("fmul_exp_a", mds_exp_a, 8'd128);
    chk("fmul_sig_a", mds_sig_a, 24'h800000);
    chk("fmul_sig_b", mds_sig_b, 24'hC00000);
    // FSQRT of the smallest subnormal, B must read as +0
    do_op(2'b10, 3'b001, 32'h00000001, 32'h7F800001, 5'd7, 2, -1, 0, 0, 0);
    chk("sqrt_sub", mds_subnormal_sqrt, 1'b1);
    chk("sqrt_exp_a", mds_exp_a, 8'd1);
    chk("sqrt_sig_a", mds_sig_a, 24'h000001);
    chk("sqrt_b_class", {mds_zero_b, mds_inf_b, mds_nan_b, mds_sign_b}, 4'b0000);
    chk("sqrt_b_snan_ignored", mds_signaling, 1'b0);
    do_op(2'b00, 3'b000, 32'h7F800001, 32'h3F800000, 5'd1, 1, -1, 0, 0, 0);
    chk("snan_a_nan", mds_nan_a, 1'b1);
    chk("snan_a_sig", mds_signaling, 1'b1);
    do_op(2'b01, 3'b000, 32'h7FC00000, 32'h3F800000, 5'd2, 1, -1, 0, 0, 0);
    chk("qnan_a_sig", mds_signaling, 1'b0);
    do_op(2'b00, 3'b010, 32'hFF800000, 32'h3F800000, 5'd4, 1, -1, 0, 0, 0);
    chk("ninf_class", {mds_inf_a, mds_sign_a}, 2'b11);
    // illegal op, then backpressure, then spurious done in the start cycle
    do_op(2'b11, 3'b000, 32'h12345678, 32'h0, 5'd9, 1, -1, 0, 0, 0);
    chk("ill_result", rsp_result, 32'h7FC00000);
    do_op(2'b01, 3'b000, 32'h40800000, 32'h40000000, 5'd10, 2, -1, 0, 5, 0);
    do_op(2'b00, 3'b000, 32'h3F800000, 32'h3F800000, 5'd11, 1, -1, 1, 0, 0);
    do_op(2'b01, 3'b000, 32'h3F800000, 32'h40400000, 5'd12, 4, 2, 0, 0, 0);
    do_op(2'b01, 3'b000, 32'h3F800000, 32'h40400000, 5'd13, 4, 0, 0, 0, 0);
    do_op(2'b01, 3'b000, 32'h3F800000, 32'h40400000, 5'd14, 3, 3, 0, 0, 0);
    do_op(2'b00, 3'b000, 32'h3F800000, 32'h40400000, 5'd15, 1, -1, 0, 2, 1);
    do_op(2'b00, 3'b000, 32'h3F800000, 32'h40400000, 5'd16, 1, -1, 0, 0, 2);

    // flush blocks acceptance in IDLE
    @(posedge clk); #1;
    flush = 1; req_valid = 1; req_op = 2'b00;
    @(negedge clk);
    chk("flush_blocks_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    @(negedge clk);
    chk("flush_idle_no_start", mds_start, 1'b0);
    chk("flush_idle_no_valid", rsp_valid, 1'b0);
    chk("flush_idle_ready", req_ready, 1'b1);

    // asynchronous reset in the middle of an FDIV wait
    @(posedge clk); #1;
    req_valid = 1; req_op = 2'b01; req_a = 32'h40400000; req_b = 32'h40000000; req_tag = 5'd21;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_sig_a", mds_sig_a, 24'hC00000);
    reset = 0;
    #1;
    chk("midrst_ops", {mds_start, mds_op, mds_exp_a, mds_sig_a, mds_exp_b, mds_sig_b}, '0);
    chk("midrst_rsp", {rsp_valid, rsp_result, rsp_flags, rsp_tag}, '0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    mds_done = 1;
    @(posedge clk); #1;
    mds_done = 0;
    @(negedge clk);
    chk("late_done_ignored", rsp_valid, 1'b0);
    chk("late_done_ready", req_ready, 1'b1);

    for (int i = 0; i < 120; i++) begin
      logic [1:0] op;
      int dly, fl, sel;
      op  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      dly = $urandom_range(1, 6);
      sel = $urandom_range(0, 5);
      fl  = (sel == 0) ? 0 : ((sel == 1) ? $urandom_range(1, dly) : -1);
      do_op(op, 3'($urandom), rand_val(), rand_val(), TW'($urandom), dly, fl,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_mds_issue.md
Name: fpu_mds_issue

Overview:
- Issue/retire stage directly upstream and downstream of the FPU multiply/divide/sqrt unit.
- Accepts one packed single-precision request (FMUL/FDIV/FSQRT) from the FPU decode stage over a valid/ready handshake.
- Unpacks and classifies the operands and pulses start to the MDS unit. Holds the operands stable until done, captures the result and exception flags, and presents them to writeback over a valid/ready handshake.
- Only one operation is in flight at a time.

Parameters:
TAG_W, 5, width of the destination tag carried alongside the operation
CANON_NAN, 32'h7FC00000, result returned for an illegal op code

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
flush  in  1  kill the in-flight operation
req_valid  in  1  request valid
req_ready  out  1  stage can accept a request
req_op  in  2  00 FMUL, 01 FDIV, 10 FSQRT, 11 illegal
req_rm  in  3  rounding mode (RISC-V encoding)
req_a  in  32  operand A (IEEE-754 single)
req_b  in  32  operand B (ignored for FSQRT)
req_tag  in  TAG_W  destination tag
mds_start  out  1  one-cycle start pulse to the MDS unit
mds_op  out  2  latched op
mds_rm  out  3  latched rounding mode
mds_sign_a, mds_sign_b  out  1 each  operand signs
mds_exp_a, mds_exp_b  out  8 each  effective exponents
mds_sig_a, mds_sig_b  out  24 each  significands including the hidden bit
mds_zero_a, mds_zero_b, mds_inf_a, mds_inf_b, mds_nan_a, mds_nan_b  out  1 each  class flags
mds_signaling  out  1  signaling NaN present among the relevant operands
mds_subnormal_sqrt  out  1  FSQRT with subnormal A
mds_out  in  32  MDS result
mds_done  in  1  MDS completion
mds_of, mds_uf, mds_nv, mds_nx, mds_dz  in  1 each  MDS exception flags
rsp_valid  out  1  result valid
rsp_ready  in  1  writeback accepts the result
rsp_result  out  32  result
rsp_flags  out  5  {NV,DZ,OF,UF,NX}, matching fflags bits 4..0
rsp_tag  out  TAG_W  tag

Behaviour:
- Reset: reset is asynchronous, active-low; clock is clk. On reset:
  - state = IDLE.
  - All registered outputs = 0: mds_start, rsp_valid, rsp_result, rsp_flags, rsp_tag, and all mds_* operand and class registers.
  - Kill flag cleared.
  - Reset in any state aborts the operation silently.
- States: IDLE, ISSUE, WAIT, RESP.
- req_ready = (state==IDLE) && !flush, combinational.
- IDLE: on req_valid && req_ready:
  - Register op, rm, tag and the unpacked operands.
  - op 11: go to RESP next cycle with rsp_result=CANON_NAN and rsp_flags=5'b10000; no mds_start.
  - Otherwise: go to ISSUE.
- ISSUE: mds_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On mds_done, capture mds_out into rsp_result and the flags into rsp_flags, then go to RESP.
  - A done arriving in the same cycle as the ISSUE start pulse is not possible. If mds_done is high in ISSUE, ignore it.
- RESP:
  - rsp_valid=1, with result, flags and tag stable until the handshake.
  - On rsp_ready, go to IDLE with rsp_valid=0 the following cycle.
- Latency: accept at cycle 0, start at cycle 1, done at cycle N, rsp_valid at cycle N+1. Throughput is one op per N+2 cycles minimum.
- mds_* operand outputs stay constant from ISSUE until leaving WAIT.
- Unpack (per operand, e = exponent field, f = fraction field):
  - zero: e==0 && f==0
  - inf: e==FF && f==0
  - nan: e==FF && f!=0
  - subnormal (e==0, f!=0): exp = 8'd1, sig = {1'b0,f}
  - normal: exp = e, sig = {1'b1,f}; zero: exp = 0, sig = 0
  - signaling: nan && f[22]==0
- mds_signaling = sNaN(A) | (op!=FSQRT && sNaN(B)).
- mds_subnormal_sqrt = (op==FSQRT) && A subnormal.
- For FSQRT, B fields are driven as +0 class (all B outputs 0).
- Flush:
  - IDLE: no effect.
  - ISSUE/WAIT: set kill. The MDS unit cannot abort, so keep waiting for mds_done, then go to IDLE with no rsp_valid.
  - RESP: drop rsp_valid next cycle and go to IDLE.
  - Flush in the same cycle as rsp_ready in RESP: go to IDLE. The writeback has already consumed the response.
- Flush and req_valid in the same IDLE cycle: the request is not accepted.

Test Plan:
- FMUL, a=0x40000000, b=0x40400000, rm=000, tag=3 → mds_start one cycle after accept; mds_exp_a=128, mds_sig_a=0x800000, mds_sig_b=0xC00000; rsp_result=0x40C00000, flags=0, tag=3.
- FSQRT, a=0x00000001 → mds_subnormal_sqrt=1, mds_exp_a=1, mds_sig_a=0x000001; all B class flags 0.
- Classification: a=0x7F800001 → nan_a=1, signaling=1. a=0x7FC00000 → signaling=0. FSQRT with b=0x7F800001 → signaling=0. a=0xFF800000 → inf_a=1, sign_a=1.
- op=11 → no mds_start; rsp_valid one cycle after accept, result 0x7FC00000, flags 5'b10000.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → result, flags and tag stable, req_ready=0; release → IDLE next cycle and a new request is accepted.
- Flush during FDIV WAIT → no rsp_valid, req_ready returns the cycle after mds_done. Reset asserted mid-WAIT → all outputs 0 immediately, req_ready=1 after release.
